// File: rtl/md_unit_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states and
// default latencies.
package md_unit_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MFHI    = 4'd5,
    MFLO    = 4'd6,
    MTHI    = 4'd7,
    MTLO    = 4'd8
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  function automatic logic is_muldiv(logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_div(logic [3:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// E-stage request/response bundle between the pipeline and the MD unit.
// master = pipeline/control side, slave = md_unit_ctrl.
interface md_unit_ctrl_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        md_stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport master (
    output start, md_op, rs_val, rt_val, d_is_md,
    input  busy, md_stall, done, hi, lo, rdata
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, d_is_md,
    output busy, md_stall, done, hi, lo, rdata
  );
endinterface

// File: rtl/md_unit_ctrl_core.sv
// Combinational multiply/divide datapath; results are only meaningful for
// MULT/MULTU/DIV/DIVU, everything else yields zeros.
module md_unit_ctrl_core
  import md_unit_ctrl_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  always_comb begin
    res_hi      = '0;
    res_lo      = '0;
    div_by_zero = 1'b0;
    a_s         = $signed(rs_val);
    b_s         = $signed(rt_val);
    prod_s      = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u      = {32'b0, rs_val} * {32'b0, rt_val};

    case (md_op)
      MULT:  {res_hi, res_lo} = prod_s;
      MULTU: {res_hi, res_lo} = prod_u;
      // Division is guarded so a zero divisor never reaches the operator.
      DIV: begin
        if (rt_val == '0) begin
          div_by_zero = 1'b1;
        end else begin
          res_lo = a_s / b_s;
          res_hi = a_s % b_s;
        end
      end
      DIVU: begin
        if (rt_val == '0) begin
          div_by_zero = 1'b1;
        end else begin
          res_lo = rs_val / rt_val;
          res_hi = rs_val % rt_val;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// HI/LO sequencer: holds the MD resource busy for a fixed latency per mult/div,
// commits results at the end, and serves mfhi/mflo/mthi/mtlo in one cycle.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic           clk,
  input logic           reset,
  md_unit_ctrl_if.slave bus
);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        dbz_q, dbz_d;
  logic        done_q, done_d;

  logic [31:0] core_hi, core_lo;
  logic        core_dbz;

  md_unit_ctrl_core u_core (
    .md_op       (bus.md_op),
    .rs_val      (bus.rs_val),
    .rt_val      (bus.rt_val),
    .res_hi      (core_hi),
    .res_lo      (core_lo),
    .div_by_zero (core_dbz)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_muldiv(bus.md_op)) begin
            res_hi_d = core_hi;
            res_lo_d = core_lo;
            dbz_d    = core_dbz;
            cnt_d    = is_div(bus.md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            state_d  = BUSY;
          end else if (bus.md_op == MTHI) begin
            hi_d = bus.rs_val;
          end else if (bus.md_op == MTLO) begin
            lo_d = bus.rs_val;
          end
        end
      end
      BUSY: begin
        // Any start seen here is a protocol violation and is deliberately dropped.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!dbz_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = (state_q == BUSY);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.md_stall = bus.d_is_md & ((state_q == BUSY) | (bus.start & is_muldiv(bus.md_op)));

  always_comb begin
    bus.rdata = '0;
    if (bus.md_op == MFHI) bus.rdata = hi_q;
    else if (bus.md_op == MFLO) bus.rdata = lo_q;
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: a vector table of ops with hand-computed
// HI/LO and busy lengths, plus sequences for stall, mfhi and mid-op reset.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  md_unit_ctrl_if bus ();

  md_unit_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      assert (!(bus.start && bus.busy)) else $error("start issued while busy");
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  n;
    logic saw_done;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = v.op;
    bus.rs_val = v.rs;
    bus.rt_val = v.rt;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.md_op  = MD_NONE;
    bus.rs_val = 32'hDEAD_BEEF;
    bus.rt_val = 32'h0000_0003;
    n = 0;
    saw_done = 1'b0;
    while (bus.busy && n < 40) begin
      n++;
      saw_done |= bus.done;
      @(negedge clk);
    end
    check($sformatf("v%0d busy_cycles", idx), 32'(n), 32'(v.cyc));
    check($sformatf("v%0d done_during_busy", idx), {31'b0, saw_done}, 32'h0);
    check($sformatf("v%0d done", idx), {31'b0, bus.done}, {31'b0, (v.cyc > 0)});
    check($sformatf("v%0d hi", idx), bus.hi, v.hi);
    check($sformatf("v%0d lo", idx), bus.lo, v.lo);
    @(negedge clk);
    check($sformatf("v%0d done_width", idx), {31'b0, bus.done}, 32'h0);
  endtask

  initial begin
    int n;
    logic saw_done;

    vecs[0]  = '{MULT,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1]  = '{MULTU,   32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2]  = '{DIV,     32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{MTHI,    32'h0000_0011, 32'h0000_0000, 32'h0000_0011, 32'hFFFF_FFFD, 0};
    vecs[4]  = '{MTLO,    32'h0000_0022, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 0};
    vecs[5]  = '{DIVU,    32'h0000_0064, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 10};
    vecs[6]  = '{MULT,    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[7]  = '{DIV,     32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[8]  = '{DIVU,    32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10};
    vecs[9]  = '{DIV,     32'h0000_0005, 32'h0000_0000, 32'h0000_0002, 32'h0000_000E, 10};
    vecs[10] = '{MD_NONE, 32'h0000_0099, 32'h0000_0001, 32'h0000_0002, 32'h0000_000E, 0};
    vecs[11] = '{4'hF,    32'h0000_0099, 32'h0000_0001, 32'h0000_0002, 32'h0000_000E, 0};
    vecs[12] = '{MULTU,   32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};

    total = 0;
    bad   = 0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.md_op   = MD_NONE;
    bus.rs_val  = '0;
    bus.rt_val  = '0;
    bus.d_is_md = 1'b1;
    repeat (3) @(negedge clk);

    check("rst busy", {31'b0, bus.busy}, 32'h0);
    check("rst done", {31'b0, bus.done}, 32'h0);
    check("rst hi", bus.hi, 32'h0);
    check("rst lo", bus.lo, 32'h0);
    check("rst stall", {31'b0, bus.md_stall}, 32'h0);
    reset = 1'b1;
    bus.d_is_md = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Stall follows d_is_md through the whole op and drops in the done cycle.
    @(negedge clk);
    bus.d_is_md = 1'b1;
    bus.start   = 1'b1;
    bus.md_op   = MULT;
    bus.rs_val  = 32'h3;
    bus.rt_val  = 32'h4;
    #1 check("stall start", {31'b0, bus.md_stall}, 32'h1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NONE;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("stall busy%0d", c), {31'b0, bus.md_stall}, 32'h1);
      @(negedge clk);
    end
    check("stall done cyc", {31'b0, bus.md_stall}, 32'h0);
    check("stall done", {31'b0, bus.done}, 32'h1);
    check("stall lo", bus.lo, 32'hC);
    bus.d_is_md = 1'b0;
    bus.start   = 1'b1;
    bus.md_op   = MULT;
    #1 check("nostall start", {31'b0, bus.md_stall}, 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NONE;
    check("nostall busy", {31'b0, bus.md_stall}, 32'h0);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("nostall drain", 32'(n), 32'h5);
    @(negedge clk);

    // MTHI then MFHI on the next cycle; MFLO reads LO combinationally.
    bus.start  = 1'b1;
    bus.md_op  = MTHI;
    bus.rs_val = 32'h0000_1234;
    @(negedge clk);
    bus.md_op = MFHI;
    #1 check("mfhi rdata", bus.rdata, 32'h0000_1234);
    bus.md_op = MFLO;
    #1 check("mflo rdata", bus.rdata, 32'h0000_000C);
    bus.md_op = MTLO;
    #1 check("mtlo rdata", bus.rdata, 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NONE;

    // Reset during busy cycle 4 of a DIV aborts it with no done pulse.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = DIV;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NONE;
    repeat (3) @(negedge clk);
    check("abort pre busy", {31'b0, bus.busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("abort busy", {31'b0, bus.busy}, 32'h0);
    check("abort hi", bus.hi, 32'h0);
    check("abort lo", bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      saw_done |= bus.done | bus.busy;
      @(negedge clk);
    end
    check("abort no done", {31'b0, saw_done}, 32'h0);
    check("abort hi kept", bus.hi, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
